dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Owns the single data-memory port and shares it between two requesters: committed stores retired from the LSQ, and loads issued by FU_mem.
- Buffers retired stores in a small store FIFO. Arbitrates between the FIFO and loads with a starvation guard.
- Blocks loads that match a pending store word, sequences one outstanding memory transaction, and formats the load result for writeback.

Parameters:
- SB_DEPTH, 4, store FIFO entries (power of 2).
- MAX_LOAD_STREAK, 4, consecutive load grants allowed while a store is pending.
- PREG_W, 7, physical register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- store_wb  in  1  LSQ retire pulse for a store
- store_addr  in  32  store byte address
- store_data  in  32  store data (ps2_data)
- store_sh  in  1  1 = sh, 0 = sw
- sb_full  out  1  store FIFO full; LSQ gates retire with it
- sb_overflow  out  1  sticky: store_wb seen while full
- ld_valid  in  1  load request from FU_mem
- ld_ready  out  1  load accepted this cycle
- ld_addr  in  32  load byte address
- ld_func3  in  3  010 = lw, 100 = lbu
- ld_rob_tag  in  5  ROB tag
- ld_pd  in  PREG_W  destination physical register
- flush  in  1  mispredict flush; kills an in-flight load
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2], 2'b00})
- mem_wdata  out  32  write data, lane-aligned
- mem_be  out  4  byte enables
- mem_resp_valid  in  1  read data valid
- mem_rdata  in  32  read data
- ld_done  out  1  load result pulse
- ld_data  out  32  formatted load data
- ld_done_rob_tag  out  5  ROB tag of the completed load
- ld_done_pd  out  PREG_W  destination physical register of the completed load

Behaviour:
Reset (reset = 0, asynchronous):
- State returns to IDLE. FIFO count and pointers clear. Streak counter clears. Kill flag clears.
- All outputs are 0, including sb_overflow.
- A reset mid-transaction abandons the transaction; the memory model must tolerate this.

Store FIFO:
- Push on store_wb when count < SB_DEPTH.
- sb_full = (count == SB_DEPTH), decoded from the count register.
- store_wb while sb_full drops the store and sets sb_overflow, even if a pop occurs the same cycle.
- Pop when a store request handshakes (mem_req_valid & mem_req_ready & mem_we).
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo SB_DEPTH.

Load hazard:
- ld_blocked = any valid FIFO entry with addr[31:2] == ld_addr[31:2].
- The head entry counts while its request is still unaccepted.

FSM states:
- IDLE
  - Arbitrate. Store wins if the FIFO is non-empty and (load not eligible, or streak == MAX_LOAD_STREAK, or sb_full).
  - Otherwise an eligible load wins. A load is eligible when ld_valid & !ld_blocked & !flush.
  - Load grant: ld_ready = 1 for one cycle; latch tag, pd, func3, addr[1:0]; streak++ when the FIFO is non-empty; go to REQ.
  - Store grant: streak = 0; go to REQ.
  - No grant: stay in IDLE.
- REQ
  - mem_req_valid = 1. Request fields are held stable until mem_req_ready; a request is never retracted.
  - Store accepted: pop the FIFO and return to IDLE.
  - Load accepted: go to WAIT.
- WAIT
  - On mem_resp_valid, return to IDLE.
  - ld_done = 1 for one cycle with formatted data, unless the kill flag is set.
- The next grant occurs at the earliest in the cycle after returning to IDLE, so there is one transaction at a time.
- Latency: load accepted at cycle T with mem_req_ready = 1 at T+1 and response at T+2 gives ld_done at T+2.

Flush:
- A flush in REQ or WAIT for a load sets the kill flag. The transaction completes, but ld_done is suppressed.
- The kill flag clears on return to IDLE.
- Stores are never flushed.

Formatting:
- sw: be = 1111, wdata = data.
- sh: be = 0011 << (2*addr[1]), wdata = {data[15:0], data[15:0]}.
- lw: data = rdata.
- lbu: data = {24'b0, rdata[8*addr[1:0] +: 8]}.
- Any other func3 is treated as lw.

Decomposition:
- types_pkg additions:
  - sb_entry_t struct {addr, data, sh}
  - arb_state_t enum {IDLE, REQ, WAIT}
  - constants F3_LW = 3'b010, F3_LBU = 3'b100, F3_SW = 3'b010, F3_SH = 3'b001
- One sub-module: store_fifo. It holds the storage, count, and pointers, and exposes the match vector against a probe address.
- The FSM, arbitration, and formatting stay in dmem_arbiter.

Test Plan:
- Isolated lw: ld_addr = 0x100 with memory returning 0xDEADBEEF a cycle after acceptance -> one read request with be = 1111, addr 0x100; ld_done with 0xDEADBEEF, correct tag/pd.
- Store hazard: sw 0x55 to 0x200, then lw 0x202 while the store is still queued -> ld_ready stays 0 until the store is accepted; then the load issues; no ld_done before the write handshake.
- Formatting: sh 0xABCD to 0x106 -> be = 1100, wdata = 0xABCDABCD. lbu 0x103 with rdata 0x11223344 -> ld_data = 0x00000011.
- Starvation guard: continuous non-conflicting loads with 1 store queued, MAX_LOAD_STREAK = 4 -> exactly 4 load grants, then the store grant, streak reset.
- FIFO full: 4 store_wb with mem_req_ready = 0 -> sb_full = 1. A fifth store_wb -> dropped, sb_overflow = 1 and sticky.
- Flush: flush during WAIT -> mem response consumed, no ld_done, FSM back in IDLE. Reset asserted in REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module  : dmem_arbiter_pkg
// Brief   : Shared types, constants and lane-formatting helpers for the
//           data-memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SH  = 3'b001;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        sh;
   } sb_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_t;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic addr1);
      logic [3:0] be;
      case (f3)
         F3_SH:   be = 4'b0011 << {addr1, 1'b0};
         F3_SW:   be = 4'b1111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
      logic [31:0] wd;
      case (f3)
         F3_SH:   wd = {data[15:0], data[15:0]};
         default: wd = data;
      endcase
      return wd;
   endfunction

   // Anything that is not lbu is returned as a full word.
   function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
      logic [31:0] shifted;
      logic [31:0] res;
      shifted = rdata >> {lo, 3'b000};
      case (f3)
         F3_LBU:  res = {24'b0, shifted[7:0]};
         F3_LW:   res = rdata;
         default: res = rdata;
      endcase
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_store_fifo.sv
// ============================================================================
// Module  : store_fifo
// Brief   : Retired-store FIFO with a word-address match vector used to block
//           loads that would bypass a pending store.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module store_fifo
   import dmem_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  sb_entry_t        i_entry,
   input  logic             i_pop,
   input  logic [29:0]      i_probe_word,
   output sb_entry_t        o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [DEPTH-1:0] o_match
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   sb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_entry;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);

   // An entry is live when its distance from the read pointer is below count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] w_off;
      assign w_off       = PTR_W'(gi) - r_rd_ptr;
      assign o_match[gi] = (CNT_W'(w_off) < r_count) &&
                           (r_mem[gi].addr[31:2] == i_probe_word);
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Shares the single data-memory port between buffered retired
//           stores and FU_mem loads, one transaction at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int SB_DEPTH        = 4,
   parameter int MAX_LOAD_STREAK = 4,
   parameter int PREG_W          = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              store_wb,
   input  logic [31:0]       store_addr,
   input  logic [31:0]       store_data,
   input  logic              store_sh,
   output logic              sb_full,
   output logic              sb_overflow,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [31:0]       ld_addr,
   input  logic [2:0]        ld_func3,
   input  logic [4:0]        ld_rob_tag,
   input  logic [PREG_W-1:0] ld_pd,
   input  logic              flush,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_rdata,
   output logic              ld_done,
   output logic [31:0]       ld_data,
   output logic [4:0]        ld_done_rob_tag,
   output logic [PREG_W-1:0] ld_done_pd
);

   localparam int STREAK_W = $clog2(MAX_LOAD_STREAK + 1);

   arb_state_t          r_state;
   arb_state_t          w_next_state;
   sb_entry_t           w_head;
   sb_entry_t           w_push_entry;
   logic                w_full;
   logic                w_empty;
   logic [SB_DEPTH-1:0] w_match;
   logic                w_push;
   logic                w_pop;
   logic                w_ld_eligible;
   logic                w_store_wins;
   logic                w_grant_ld;
   logic                w_grant_st;
   logic                w_req_active;
   logic                w_done;
   logic [2:0]          w_st_f3;
   logic                w_unused;

   logic                r_is_store;
   logic [31:0]         r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic [3:0]          r_mem_be;
   logic [4:0]          r_ld_tag;
   logic [PREG_W-1:0]   r_ld_pd;
   logic [2:0]          r_ld_f3;
   logic [1:0]          r_ld_lo;
   logic [STREAK_W-1:0] r_streak;
   logic                r_kill;
   logic                r_sb_overflow;

   assign w_push_entry = '{addr: store_addr, data: store_data, sh: store_sh};
   assign w_push       = store_wb && !w_full;

   store_fifo #(
      .DEPTH (SB_DEPTH)
   ) u_store_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_push       (w_push),
      .i_entry      (w_push_entry),
      .i_pop        (w_pop),
      .i_probe_word (ld_addr[31:2]),
      .o_head       (w_head),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_match      (w_match)
   );

   assign w_ld_eligible = ld_valid && !(|w_match) && !flush;
   assign w_store_wins  = !w_empty &&
                          (!w_ld_eligible || (r_streak == STREAK_W'(MAX_LOAD_STREAK)) || w_full);
   assign w_st_f3       = w_head.sh ? F3_SH : F3_SW;
   assign w_unused      = w_head.addr[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Grants are also gated by reset so ld_ready stays low while it is held.
   always_comb begin
      w_next_state = r_state;
      w_grant_ld   = 1'b0;
      w_grant_st   = 1'b0;
      w_pop        = 1'b0;
      w_req_active = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (reset) begin
               if (w_store_wins) begin
                  w_grant_st   = 1'b1;
                  w_next_state = REQ;
               end else if (w_ld_eligible) begin
                  w_grant_ld   = 1'b1;
                  w_next_state = REQ;
               end
            end
         end
         REQ: begin
            w_req_active = 1'b1;
            if (mem_req_ready) begin
               w_pop        = r_is_store;
               w_next_state = r_is_store ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (mem_resp_valid) begin
               w_done       = !r_kill && !flush;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_is_store    <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_mem_be      <= '0;
         r_ld_tag      <= '0;
         r_ld_pd       <= '0;
         r_ld_f3       <= '0;
         r_ld_lo       <= '0;
         r_streak      <= '0;
         r_kill        <= 1'b0;
         r_sb_overflow <= 1'b0;
      end else begin
         if (store_wb && w_full) r_sb_overflow <= 1'b1;

         if (w_grant_st) begin
            r_is_store  <= 1'b1;
            r_mem_addr  <= {w_head.addr[31:2], 2'b00};
            r_mem_wdata <= store_wdata(w_st_f3, w_head.data);
            r_mem_be    <= store_be(w_st_f3, w_head.addr[1]);
            r_streak    <= '0;
         end else if (w_grant_ld) begin
            r_is_store  <= 1'b0;
            r_mem_addr  <= {ld_addr[31:2], 2'b00};
            r_mem_wdata <= '0;
            r_mem_be    <= 4'b1111;
            r_ld_tag    <= ld_rob_tag;
            r_ld_pd     <= ld_pd;
            r_ld_f3     <= ld_func3;
            r_ld_lo     <= ld_addr[1:0];
            if (!w_empty) r_streak <= r_streak + STREAK_W'(1);
         end

         // Kill only ever marks loads; it is dropped whenever the FSM idles.
         if (r_state == IDLE || (r_state == WAIT && mem_resp_valid)) r_kill <= 1'b0;
         else if (flush && !r_is_store)                               r_kill <= 1'b1;
      end
   end

   assign sb_full         = w_full;
   assign sb_overflow     = r_sb_overflow;
   assign ld_ready        = w_grant_ld;
   assign mem_req_valid   = w_req_active;
   assign mem_we          = w_req_active && r_is_store;
   assign mem_addr        = w_req_active ? r_mem_addr  : '0;
   assign mem_wdata       = w_req_active ? r_mem_wdata : '0;
   assign mem_be          = w_req_active ? r_mem_be    : '0;
   assign ld_done         = w_done;
   assign ld_data         = w_done ? load_format(r_ld_f3, r_ld_lo, mem_rdata) : '0;
   assign ld_done_rob_tag = w_done ? r_ld_tag : '0;
   assign ld_done_pd      = w_done ? r_ld_pd  : '0;

endmodule

`default_nettype wire
